// File: rtl/axis_frame_packer.sv
// axis_frame_packer: buffers recovered RGB pixels in a small first-word-fall-through
// FIFO and emits them as an AXI4-Stream video frame. TUSER marks the first beat of a
// frame and TLAST marks the last one. Framing follows output transfers, so dropped
// pixels shorten the frame content but never shift the frame boundaries.
module axis_frame_packer #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [23:0]                   in_pixel,
    input  logic                          in_valid,
    output logic [31:0]                   M_AXIS_TDATA,
    output logic                          M_AXIS_TVALID,
    input  logic                          M_AXIS_TREADY,
    output logic                          M_AXIS_TLAST,
    output logic                          M_AXIS_TUSER,
    input  logic                          clear_ovf,
    output logic                          overflow,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_HEIGHT - 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t        state, state_nxt;
    logic          done_nxt;
    logic [23:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          full, rd_en, wr_en, drop;
    logic          at_first, at_last;

    // FIFO handshake decode and the zero-latency output view of the FIFO head
    always_comb begin
        full          = (fifo_level == LEVEL_FULL);
        M_AXIS_TVALID = (fifo_level != '0);
        rd_en         = M_AXIS_TVALID & M_AXIS_TREADY;
        // a full FIFO still takes a pixel when the head leaves in the same cycle
        wr_en         = in_valid & (~full | rd_en);
        drop          = in_valid & full & ~rd_en;
        at_first      = (col == '0) && (row == '0);
        at_last       = (col == COL_LAST) && (row == ROW_LAST);
        M_AXIS_TDATA  = M_AXIS_TVALID ? {8'h00, mem[rd_ptr]} : '0;
        M_AXIS_TUSER  = M_AXIS_TVALID & at_first;
        M_AXIS_TLAST  = M_AXIS_TVALID & at_last;
    end

    // pixel storage; contents need no reset because the level gates visibility
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= in_pixel;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // sticky drop flag; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

    // column/row position of the beat at the FIFO head, advanced per transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (rd_en) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // frame state register and registered end-of-frame pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= done_nxt;
        end
    end

    // frame FSM: a beat that is both first and last keeps the FSM in IDLE
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (rd_en) begin
                    if (at_last) done_nxt  = 1'b1;
                    else         state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (rd_en && at_last) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axis_frame_packer.sv
// Testbench for axis_frame_packer: a 4x2 frame with a 4-deep FIFO checked against a
// queue-based reference model every cycle, plus a 1x1-frame instance.
module tb_axis_frame_packer;

    localparam int W = 4;
    localparam int H = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] in_pixel = '0;
    logic        in_valid = 1'b0;
    logic        tready = 1'b0;
    logic        clear_ovf = 1'b0;
    logic [31:0] tdata;
    logic        tvalid, tlast, tuser, ovf, fdone;
    logic [2:0]  level;

    logic [23:0] b_pixel = '0;
    logic        b_valid = 1'b0;
    logic        b_tready = 1'b0;
    logic [31:0] b_tdata;
    logic        b_tvalid, b_tlast, b_tuser, b_ovf, b_fdone;
    logic [2:0]  b_level;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // reference model state
    logic [23:0] q[$];
    int unsigned beats = 0;
    logic        m_ovf = 1'b0;
    logic        m_fd = 1'b0;

    typedef struct {
        logic        iv;
        logic [23:0] pix;
        logic        rdy;
        logic        ev;
        logic [31:0] edata;
        logic        eu;
        logic        el;
        logic [2:0]  elev;
        logic        efd;
    } vec_t;

    vec_t tbl[10];

    always #5 clk = ~clk;

    axis_frame_packer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .in_pixel(in_pixel), .in_valid(in_valid),
        .M_AXIS_TDATA(tdata), .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready),
        .M_AXIS_TLAST(tlast), .M_AXIS_TUSER(tuser), .clear_ovf(clear_ovf),
        .overflow(ovf), .frame_done(fdone), .fifo_level(level)
    );

    axis_frame_packer #(.IMG_WIDTH(1), .IMG_HEIGHT(1), .FIFO_DEPTH(4)) dut_1x1 (
        .clk(clk), .rst(rst), .in_pixel(b_pixel), .in_valid(b_valid),
        .M_AXIS_TDATA(b_tdata), .M_AXIS_TVALID(b_tvalid), .M_AXIS_TREADY(b_tready),
        .M_AXIS_TLAST(b_tlast), .M_AXIS_TUSER(b_tuser), .clear_ovf(1'b0),
        .overflow(b_ovf), .frame_done(b_fdone), .fifo_level(b_level)
    );

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk32(name, 32'(act), 32'(exp));
    endtask

    // compare every DUT output against the model's view of the current state
    task automatic check_model();
        logic v;
        v = (q.size() > 0);
        chk1("model tvalid", tvalid, v);
        chk32("model tdata", tdata, v ? {8'h00, q[0]} : 32'h0);
        chk1("model tuser", tuser, v && (beats == 0));
        chk1("model tlast", tlast, v && (beats == W * H - 1));
        chk32("model level", 32'(level), 32'(q.size()));
        chk1("model overflow", ovf, m_ovf);
        chk1("model frame_done", fdone, m_fd);
    endtask

    // one clock: drive inputs, check current outputs, advance the model, pass the edge
    task automatic cycle(input logic iv, input logic [23:0] pix, input logic rdy, input logic clr);
        logic rd, was_full, wr;
        in_valid  = iv;
        in_pixel  = pix;
        tready    = rdy;
        clear_ovf = clr;
        check_model();
        was_full = (q.size() == D);
        rd       = (q.size() > 0) && rdy;
        m_fd     = rd && (beats == W * H - 1);
        if (rd) begin
            void'(q.pop_front());
            beats = (beats + 1) % (W * H);
        end
        wr = iv && (!was_full || rd);
        if (wr) q.push_back(pix);
        if (iv && !wr)  m_ovf = 1'b1;
        else if (clr)   m_ovf = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        tready    = 1'b0;
        clear_ovf = 1'b0;
        b_valid   = 1'b0;
        rst       = 1'b1;
        // a pixel offered while reset is sampled high must not be taken
        in_valid  = 1'b1;
        in_pixel  = 24'hEEEEEE;
        #1;
        chk1("reset tvalid", tvalid, 1'b0);
        chk32("reset level", 32'(level), 32'h0);
        chk32("reset tdata", tdata, 32'h0);
        chk1("reset tuser", tuser, 1'b0);
        chk1("reset tlast", tlast, 1'b0);
        chk1("reset overflow", ovf, 1'b0);
        chk1("reset frame_done", fdone, 1'b0);
        q.delete();
        beats = 0;
        m_ovf = 1'b0;
        m_fd  = 1'b0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        chk32("reset edge no write", 32'(level), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int unsigned fd_cnt;
        int unsigned rate;

        // streaming frame: 8 pixels with TREADY held high, expectations after each edge
        for (int unsigned k = 0; k < 8; k++) begin
            tbl[k].iv = 1'b1; tbl[k].pix = 24'(k + 1); tbl[k].rdy = 1'b1;
            tbl[k].ev = 1'b1; tbl[k].edata = 32'(k + 1);
            tbl[k].eu = (k == 0); tbl[k].el = (k == 7);
            tbl[k].elev = 3'd1; tbl[k].efd = 1'b0;
        end
        tbl[8] = '{iv: 1'b0, pix: 24'h0, rdy: 1'b1, ev: 1'b0, edata: 32'h0,
                   eu: 1'b0, el: 1'b0, elev: 3'd0, efd: 1'b1};
        tbl[9] = '{iv: 1'b0, pix: 24'h0, rdy: 1'b1, ev: 1'b0, edata: 32'h0,
                   eu: 1'b0, el: 1'b0, elev: 3'd0, efd: 1'b0};

        apply_reset();

        for (int unsigned i = 0; i < 10; i++) begin
            cycle(tbl[i].iv, tbl[i].pix, tbl[i].rdy, 1'b0);
            chk1("stream tvalid", tvalid, tbl[i].ev);
            chk32("stream tdata", tdata, tbl[i].edata);
            chk1("stream tuser", tuser, tbl[i].eu);
            chk1("stream tlast", tlast, tbl[i].el);
            chk32("stream level", 32'(level), 32'(tbl[i].elev));
            chk1("stream frame_done", fdone, tbl[i].efd);
        end

        // backpressure: 10 stalled cycles, 6 pixels offered, last two dropped
        for (int unsigned i = 0; i < 10; i++) begin
            cycle(i < 6, 24'hA00001 + 24'(i), 1'b0, 1'b0);
            chk32("stall tdata stable", tdata, 32'h00A00001);
        end
        chk1("bp overflow", ovf, 1'b1);
        chk32("bp level", 32'(level), 32'd4);
        for (int unsigned i = 0; i < 4; i++) begin
            chk32("bp drain order", tdata, 32'h00A00001 + i);
            cycle(1'b0, 24'h0, 1'b1, 1'b0);
        end
        chk32("bp drained", 32'(level), 32'd0);

        // full FIFO with a simultaneous read and write
        cycle(1'b0, 24'h0, 1'b0, 1'b1);
        chk1("clear before full", ovf, 1'b0);
        for (int unsigned i = 0; i < 4; i++) cycle(1'b1, 24'hB00000 + 24'(i), 1'b0, 1'b0);
        chk32("full level", 32'(level), 32'd4);
        cycle(1'b1, 24'hB00004, 1'b1, 1'b0);
        chk32("full rw level", 32'(level), 32'd4);
        chk1("full rw overflow", ovf, 1'b0);
        chk32("full rw head", tdata, 32'h00B00001);

        // overflow clear race
        cycle(1'b1, 24'hC00000, 1'b0, 1'b0);
        chk1("drop sets ovf", ovf, 1'b1);
        cycle(1'b0, 24'h0, 1'b0, 1'b1);
        chk1("clear alone", ovf, 1'b0);
        cycle(1'b1, 24'hC00001, 1'b0, 1'b0);
        chk1("drop sets ovf again", ovf, 1'b1);
        cycle(1'b1, 24'hC00002, 1'b0, 1'b1);
        chk1("drop beats clear", ovf, 1'b1);
        chk32("drop keeps level", 32'(level), 32'd4);
        cycle(1'b0, 24'h0, 1'b0, 1'b1);
        for (int unsigned i = 0; i < 4; i++) cycle(1'b0, 24'h0, 1'b1, 1'b0);
        chk32("race drained", 32'(level), 32'd0);

        // reset mid-frame: 3 transfers, 2 pixels buffered, then reset between edges
        for (int unsigned i = 0; i < 4; i++) cycle(1'b1, 24'hD00001 + 24'(i), 1'b1, 1'b0);
        cycle(1'b1, 24'hD00005, 1'b0, 1'b0);
        chk32("midframe level", 32'(level), 32'd2);
        chk1("midframe not sof", tuser, 1'b0);
        #2;
        apply_reset();
        cycle(1'b1, 24'hE00001, 1'b1, 1'b0);
        chk1("post reset tuser", tuser, 1'b1);
        chk32("post reset tdata", tdata, 32'h00E00001);
        cycle(1'b0, 24'h0, 1'b1, 1'b0);

        // 1x1 frames on the second instance
        fd_cnt = 0;
        b_tready = 1'b1;
        for (int unsigned k = 0; k < 6; k++) begin
            b_valid = (k < 3);
            b_pixel = 24'hF00000 + 24'(k);
            cycle(1'b0, 24'h0, 1'b0, 1'b0);
            if (k < 3) begin
                chk1("1x1 tvalid", b_tvalid, 1'b1);
                chk1("1x1 tuser", b_tuser, 1'b1);
                chk1("1x1 tlast", b_tlast, 1'b1);
                chk32("1x1 tdata", b_tdata, 32'h00F00000 + k);
            end
            if (b_fdone) fd_cnt++;
        end
        b_valid = 1'b0;
        chk32("1x1 frame_done count", fd_cnt, 32'd3);
        chk32("1x1 drained", 32'(b_level), 32'd0);

        // randomized traffic against the model, first with heavy then light backpressure
        for (int unsigned i = 0; i < 600; i++) begin
            rate = (i < 300) ? 4 : 9;
            cycle($urandom_range(0, 9) < 7, 24'($urandom),
                  $urandom_range(0, 9) < rate, $urandom_range(0, 19) == 0);
        end
        check_model();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
